// File: rtl/prog_mem_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : prog_mem_loader_if
//  Purpose  : Byte-stream input and memory write port of the program-memory
//             loader, bundled as one interface.
//  Signals  : in_data/in_valid/in_ready - byte stream (valid/ready handshake)
//             wr_en/wr_addr/wr_data     - single-cycle memory write port
//  Modports : master - host side (drives the stream, observes the write port)
//             slave  - loader side
//  Revision : 1.0 - initial release
// ============================================================================
interface prog_mem_loader_if #(
    parameter int BIT_WIDTH = 16
);
    logic [7:0]           in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic                 wr_en;
    logic [15:0]          wr_addr;
    logic [BIT_WIDTH-1:0] wr_data;

    modport master (
        output in_data, in_valid,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface
`default_nettype wire

// File: rtl/prog_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : prog_mem_loader
//  Purpose  : Packs an incoming byte stream little-endian into BIT_WIDTH-bit
//             words and writes them, one single-cycle strobe per word, to
//             consecutive program-memory addresses starting at base_addr.
//  Ports    : clk        - clock, rising edge
//             rst        - asynchronous active-low reset
//             start      - begin a load (sampled only when idle)
//             base_addr  - first word address, latched on start
//             word_count - number of words, latched on start
//             abort      - cancel an active load
//             bus        - byte stream in / memory write port out
//             busy       - load in progress
//             done       - one-cycle pulse: load finished or rejected
//             error      - sticky: last load rejected as out of bounds
//  Revision : 1.0 - initial release
// ============================================================================
module prog_mem_loader #(
    parameter int BIT_WIDTH = 16,
    parameter int MEM_WORDS = 256
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          start,
    input  wire logic [15:0]   base_addr,
    input  wire logic [15:0]   word_count,
    input  wire logic          abort,
    prog_mem_loader_if.slave   bus,
    output logic               busy,
    output logic               done,
    output logic               error
);

    localparam int BYTES = BIT_WIDTH / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0] c_LAST_IDX  = IDX_W'(BYTES - 1);
    localparam logic [16:0]      c_MEM_WORDS = 17'(MEM_WORDS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_FINISH  = 2'd3
    } state_t;

    state_t               r_state;
    logic [15:0]          r_cur_addr;
    logic [15:0]          r_remaining;
    logic [IDX_W-1:0]     r_byte_idx;
    logic [BIT_WIDTH-1:0] r_asm;
    logic                 r_in_ready;
    logic                 r_wr_en;
    logic [15:0]          r_wr_addr;
    logic [BIT_WIDTH-1:0] r_wr_data;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_error;

    logic [16:0]          w_end;
    logic [BIT_WIDTH-1:0] w_asm_next;

    // 17-bit sum so a base near 0xFFFF cannot wrap and slip past the check.
    assign w_end = {1'b0, base_addr} + {1'b0, word_count};

    // Assembly register with the byte currently on the stream merged in.
    always_comb begin
        w_asm_next = r_asm;
        w_asm_next[8*r_byte_idx +: 8] = bus.in_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cur_addr  <= '0;
            r_remaining <= '0;
            r_byte_idx  <= '0;
            r_asm       <= '0;
            r_in_ready  <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_wr_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cur_addr  <= base_addr;
                        r_remaining <= word_count;
                        r_byte_idx  <= '0;
                        r_asm       <= '0;
                        r_busy      <= 1'b1;
                        if (w_end > c_MEM_WORDS) begin
                            r_error <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_FINISH;
                        end else if (word_count == 16'd0) begin
                            r_error <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_FINISH;
                        end else begin
                            r_error    <= 1'b0;
                            r_in_ready <= 1'b1;
                            r_state    <= S_COLLECT;
                        end
                    end
                end
                S_COLLECT: begin
                    if (abort) begin
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b0;
                        r_asm      <= '0;
                        r_byte_idx <= '0;
                        r_state    <= S_IDLE;
                    end else if (bus.in_valid) begin
                        r_asm <= w_asm_next;
                        if (r_byte_idx == c_LAST_IDX) begin
                            // Word complete: present it on the write port next cycle.
                            r_in_ready <= 1'b0;
                            r_wr_en    <= 1'b1;
                            r_wr_addr  <= r_cur_addr;
                            r_wr_data  <= w_asm_next;
                            r_state    <= S_WRITE;
                        end else begin
                            r_byte_idx <= r_byte_idx + IDX_W'(1);
                        end
                    end
                end
                S_WRITE: begin
                    r_asm      <= '0;
                    r_byte_idx <= '0;
                    if (abort) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cur_addr  <= r_cur_addr + 16'd1;
                        r_remaining <= r_remaining - 16'd1;
                        if (r_remaining == 16'd1) begin
                            r_done  <= 1'b1;
                            r_state <= S_FINISH;
                        end else begin
                            r_in_ready <= 1'b1;
                            r_state    <= S_COLLECT;
                        end
                    end
                end
                S_FINISH: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    // The strobe is registered on entry to WRITE; an abort arriving in that
    // same cycle must still cancel it, so it is gated here.
    assign bus.wr_en    = r_wr_en & ~abort;
    assign bus.in_ready = r_in_ready;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_data  = r_wr_data;
    assign busy         = r_busy;
    assign done         = r_done;
    assign error        = r_error;

endmodule
`default_nettype wire
